// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the single-port RAM arbiter.
package ram_arb_pkg;
  localparam int ADDR_W_DEF = 11;
  localparam int DATA_W_DEF = 8;
  localparam int DEPTH      = 2**ADDR_W_DEF;
  localparam int TOP_ADDR   = DEPTH-1;

  typedef enum logic [1:0] {GNT_NONE, GNT_WR, GNT_RD} grant_t;
endpackage

// File: rtl/ram_ptr.sv
// Descending circular-buffer pointer; reset/clear park it at the top address.
module ram_ptr #(
  parameter int W = 11
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         dec_i,
  output logic [W-1:0] ptr_o
);
  logic [W-1:0] ptr_q;

  // Modular decrement gives the 0 -> top wrap for free.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) ptr_q <= '1;
    else if (dec_i)     ptr_q <= ptr_q - 1'b1;
  end

  assign ptr_o = ptr_q;
endmodule

// File: rtl/ram_arb.sv
// Round-robin arbiter sharing one single-port RAM between a write stream and a
// read drain, with the RAM managed as a top-down circular buffer.
module ram_arb
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_2,
  input  logic              reset,
  input  logic              clr,
  input  logic              wr_req,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              rd_req,
  output logic              rd_ack,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic              ram_re,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              ovf
);
  localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_q, rd_data_q;
  logic [ADDR_W:0]   count_q;
  logic              wr_ack_q, rd_ack_q, ram_we_q, ram_re_q, rd_vld_q, ovf_q;
  grant_t            last_q, gnt_d;
  logic              wr_ok, rd_ok;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  // Ack masking stops the still-high request from being granted twice.
  assign wr_ok = wr_req & ~full  & ~wr_ack_q;
  assign rd_ok = rd_req & ~empty & ~rd_ack_q;

  always_comb begin
    gnt_d = GNT_NONE;
    if (!clr) begin
      if (wr_ok && rd_ok) gnt_d = (last_q == GNT_RD) ? GNT_WR : GNT_RD;
      else if (wr_ok)     gnt_d = GNT_WR;
      else if (rd_ok)     gnt_d = GNT_RD;
    end
  end

  ram_ptr #(.W(ADDR_W)) u_wr_ptr (
    .clk_i(clk_2), .rst_i(reset), .clr_i(clr),
    .dec_i(!reset && gnt_d == GNT_WR), .ptr_o(wr_ptr)
  );

  ram_ptr #(.W(ADDR_W)) u_rd_ptr (
    .clk_i(clk_2), .rst_i(reset), .clr_i(clr),
    .dec_i(!reset && gnt_d == GNT_RD), .ptr_o(rd_ptr)
  );

  always_ff @(posedge clk_2) begin
    if (reset || clr) begin
      wr_ack_q    <= 1'b0;
      rd_ack_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_re_q    <= 1'b0;
      rd_vld_q    <= 1'b0;
      rd_data_q   <= '0;
      ram_wdata_q <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      last_q      <= GNT_RD;
      if (reset) ram_addr_q <= '1;
    end else begin
      wr_ack_q <= (gnt_d == GNT_WR);
      rd_ack_q <= (gnt_d == GNT_RD);
      ram_we_q <= (gnt_d == GNT_WR);
      ram_re_q <= (gnt_d == GNT_RD);
      rd_vld_q <= ram_re_q;
      if (rd_vld_q) rd_data_q <= ram_rdata;
      if (wr_req && full) ovf_q <= 1'b1;
      if (gnt_d == GNT_WR) begin
        ram_addr_q  <= wr_ptr;
        ram_wdata_q <= wr_data;
        count_q     <= count_q + 1'b1;
        last_q      <= GNT_WR;
      end else if (gnt_d == GNT_RD) begin
        ram_addr_q <= rd_ptr;
        count_q    <= count_q - 1'b1;
        last_q     <= GNT_RD;
      end
    end
  end

  // RAM data arrives in the rd_valid cycle, so forward it then and hold it after.
  assign rd_data   = rd_vld_q ? ram_rdata : rd_data_q;
  assign rd_valid  = rd_vld_q;
  assign wr_ack    = wr_ack_q;
  assign rd_ack    = rd_ack_q;
  assign ram_we    = ram_we_q;
  assign ram_re    = ram_re_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign count     = count_q;
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_ram_arb.sv
// Directed bench for ram_arb: cycle table plus hand sequences for tie, full and clr cases.
module tb_ram_arb;
  logic        clk_2 = 1'b0;
  logic        reset = 1'b1, clr = 1'b0;
  logic        wr_req = 1'b0, rd_req = 1'b0;
  logic [7:0]  wr_data = '0;
  logic        wr_ack, rd_ack, rd_valid, ram_we, ram_re, full, empty, ovf;
  logic [7:0]  rd_data, ram_wdata;
  logic [7:0]  ram_rdata = '0;
  logic [10:0] ram_addr;
  logic [11:0] count;
  logic [7:0]  mem [2048];

  int n_cmp = 0, n_bad = 0;

  ram_arb dut (
    .clk_2(clk_2), .reset(reset), .clr(clr),
    .wr_req(wr_req), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_ack(rd_ack), .rd_valid(rd_valid), .rd_data(rd_data),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_re(ram_re),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .count(count), .full(full), .empty(empty), .ovf(ovf)
  );

  always #5 clk_2 = ~clk_2;

  // Synchronous single-port RAM: read data valid the cycle after ram_re.
  always @(posedge clk_2) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_re) ram_rdata <= mem[ram_addr];
  end

  typedef struct packed {
    logic        rst, wr, rd;
    logic [7:0]  wd;
    logic [4:0]  flags;  // {wr_ack, rd_ack, rd_valid, ram_we, ram_re}
    logic [7:0]  rdat;
    logic [10:0] addr;
    logic [7:0]  wdat;
    logic [11:0] cnt;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_2); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; step(); reset = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] d, output logic [10:0] a);
    bit got = 0;
    wr_req = 1'b1; wr_data = d; a = '0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (wr_ack) begin got = 1; a = ram_addr; end
    end
    wr_req = 1'b0;
    if (!got) chk("write_timeout", 0, 1);
  endtask

  task automatic do_read(output logic [10:0] a);
    bit got = 0;
    rd_req = 1'b1; a = '0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (rd_ack) begin got = 1; a = ram_addr; end
    end
    rd_req = 1'b0;
    if (!got) chk("read_timeout", 0, 1);
  endtask

  initial begin
    logic [10:0] a;
    int acks, bad_coinc, nowack;
    //                   rst wr rd  wd     flags    rdat   addr     wdat   cnt
    tbl[0]  = '{1'b1,1'b0,1'b0,8'h00,5'b00000,8'h00,11'h7FF,8'h00,12'd0};
    tbl[1]  = '{1'b0,1'b1,1'b0,8'hA5,5'b10010,8'h00,11'h7FF,8'hA5,12'd1};
    tbl[2]  = '{1'b0,1'b0,1'b0,8'h00,5'b00000,8'h00,11'h7FF,8'hA5,12'd1};
    tbl[3]  = '{1'b1,1'b0,1'b0,8'h00,5'b00000,8'h00,11'h7FF,8'h00,12'd0};
    tbl[4]  = '{1'b0,1'b1,1'b0,8'h11,5'b10010,8'h00,11'h7FF,8'h11,12'd1};
    tbl[5]  = '{1'b0,1'b1,1'b0,8'h22,5'b00000,8'h00,11'h7FF,8'h11,12'd1};
    tbl[6]  = '{1'b0,1'b1,1'b0,8'h22,5'b10010,8'h00,11'h7FE,8'h22,12'd2};
    tbl[7]  = '{1'b0,1'b0,1'b1,8'h00,5'b01001,8'h00,11'h7FF,8'h22,12'd1};
    tbl[8]  = '{1'b0,1'b0,1'b1,8'h00,5'b00100,8'h11,11'h7FF,8'h22,12'd1};
    tbl[9]  = '{1'b0,1'b0,1'b1,8'h00,5'b01001,8'h11,11'h7FE,8'h22,12'd0};
    tbl[10] = '{1'b0,1'b0,1'b0,8'h00,5'b00100,8'h22,11'h7FE,8'h22,12'd0};
    tbl[11] = '{1'b0,1'b0,1'b1,8'h00,5'b00000,8'h22,11'h7FE,8'h22,12'd0};
    tbl[12] = '{1'b0,1'b1,1'b1,8'h33,5'b10010,8'h22,11'h7FD,8'h33,12'd1};
    tbl[13] = '{1'b0,1'b0,1'b1,8'h00,5'b01001,8'h22,11'h7FD,8'h33,12'd0};
    tbl[14] = '{1'b0,1'b0,1'b0,8'h00,5'b00100,8'h33,11'h7FD,8'h33,12'd0};

    #1;
    for (int i = 0; i < 15; i++) begin
      reset = tbl[i].rst; wr_req = tbl[i].wr; rd_req = tbl[i].rd; wr_data = tbl[i].wd;
      step();
      chk($sformatf("v%0d.flags", i), {wr_ack, rd_ack, rd_valid, ram_we, ram_re}, tbl[i].flags);
      chk($sformatf("v%0d.rd_data", i), rd_data, tbl[i].rdat);
      chk($sformatf("v%0d.ram_addr", i), ram_addr, tbl[i].addr);
      chk($sformatf("v%0d.ram_wdata", i), ram_wdata, tbl[i].wdat);
      chk($sformatf("v%0d.count", i), count, tbl[i].cnt);
      if (i == 0) chk("reset.flags", {empty, full, ovf}, 3'b100);
    end
    reset = 1'b0; wr_req = 1'b0; rd_req = 1'b0;

    // Tie: 6 writes, 1 read leaves count=5 with last grant RD, so W wins first.
    do_reset();
    for (int i = 0; i < 6; i++) do_write(8'(i + 8'h40), a);
    do_read(a);
    step();
    chk("tie.count", count, 12'd5);
    wr_req = 1'b1; rd_req = 1'b1; wr_data = 8'h99; bad_coinc = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("tie.gnt%0d", i), {wr_ack, rd_ack}, (i % 2 == 0) ? 2'b10 : 2'b01);
      if (ram_we && ram_re) bad_coinc++;
    end
    wr_req = 1'b0; rd_req = 1'b0;
    chk("tie.we_re_overlap", bad_coinc, 0);

    // Fill to full, overflow, then wrap of both pointers.
    do_reset();
    acks = 0; wr_req = 1'b1; wr_data = 8'h01;
    for (int i = 0; i < 5000 && acks < 2048; i++) begin
      step();
      if (wr_ack) begin acks++; wr_data = 8'(acks + 1); end
    end
    chk("fill.acks", acks, 2048);
    chk("fill.count", count, 12'd2048);
    chk("fill.full_ovf", {full, empty, ovf}, 3'b100);
    nowack = 0;
    for (int i = 0; i < 3; i++) begin step(); if (wr_ack) nowack++; end
    wr_req = 1'b0;
    chk("full.no_ack", nowack, 0);
    chk("full.ovf", ovf, 1'b1);
    do_read(a);
    chk("wrap.rd_addr", a, 11'h7FF);
    step();
    chk("wrap.rd_valid", rd_valid, 1'b1);
    chk("wrap.rd_data", rd_data, 8'h01);
    chk("wrap.ovf_sticky", ovf, 1'b1);
    do_write(8'h5A, a);
    chk("wrap.wr_addr", a, 11'h7FF);
    chk("wrap.count", count, 12'd2048);

    // clr the cycle after a read grant: read data is dropped, state flushed.
    do_read(a);
    chk("clr.rd_addr", a, 11'h7FE);
    clr = 1'b1; step(); clr = 1'b0;
    chk("clr.rd_valid", rd_valid, 1'b0);
    chk("clr.count", count, 12'd0);
    chk("clr.flags", {empty, full, ovf}, 3'b100);
    chk("clr.ram_addr_kept", ram_addr, 11'h7FE);
    step();
    chk("clr.rd_valid_late", rd_valid, 1'b0);
    do_write(8'h77, a);
    chk("clr.wr_addr", a, 11'h7FF);
    chk("clr.count_after", count, 12'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
